// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared XADAC types and arbiter ID-width rule
package xadac_pkg;

   localparam int IdWidth      = 4;
   localparam int AddrWidth    = 32;
   localparam int VecDataWidth = 64;

   typedef logic [IdWidth-1:0]      IdT;
   typedef logic [AddrWidth-1:0]    AddrT;
   typedef logic [VecDataWidth-1:0] VecDataT;

   // Requester-index field width; never below one bit so the field always exists.
   function automatic int arb_idx_width(input int num_req);
      int w;
      w = $clog2(num_req);
      return (w < 1) ? 1 : w;
   endfunction

   // Downstream ID = {requester index, local ID}.
   function automatic int arb_id_width(input int num_req);
      return IdWidth + arb_idx_width(num_req);
   endfunction

endpackage

// File: rtl/xadac_rr_arb.sv
// rtl/xadac_rr_arb.sv - round-robin priority picker, one-hot grant
module xadac_rr_arb #(
   parameter int N    = 2,
   parameter int PtrW = 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o
);

   int   idx;
   logic found;

   // Scan from ptr_i upward with wrap; the first requesting slot wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= N) idx = idx - N;
         for (int j = 0; j < N; j++) begin
            if (j == idx && !found && req_i[j]) begin
               gnt_o[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/xadac_axi_rd_arb.sv
// rtl/xadac_axi_rd_arb.sv - N-to-1 AXI read arbiter with per-requester outstanding limit
module xadac_axi_rd_arb
   import xadac_pkg::*;
#(
   parameter  int NumReq         = 2,
   parameter  int MaxOutstanding = 4,
   localparam int IdxWidth       = arb_idx_width(NumReq),
   localparam int ArbIdWidth     = arb_id_width(NumReq)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  IdT      [NumReq-1:0]  slv_ar_id,
   input  AddrT    [NumReq-1:0]  slv_ar_addr,
   input  logic    [NumReq-1:0]  slv_ar_valid,
   output logic    [NumReq-1:0]  slv_ar_ready,
   output IdT      [NumReq-1:0]  slv_r_id,
   output VecDataT [NumReq-1:0]  slv_r_data,
   output logic    [NumReq-1:0]  slv_r_valid,
   input  logic    [NumReq-1:0]  slv_r_ready,
   output logic [ArbIdWidth-1:0] mst_ar_id,
   output AddrT                  mst_ar_addr,
   output logic                  mst_ar_valid,
   input  logic                  mst_ar_ready,
   input  logic [ArbIdWidth-1:0] mst_r_id,
   input  VecDataT               mst_r_data,
   input  logic                  mst_r_valid,
   output logic                  mst_r_ready,
   output logic                  err
);

   localparam int CntWidth = $clog2(MaxOutstanding + 1);
   typedef logic [CntWidth-1:0] cnt_t;

   cnt_t [NumReq-1:0]     cnt_q, cnt_d;
   logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
   logic                  ar_valid_q, ar_valid_d;
   logic [ArbIdWidth-1:0] ar_id_q, ar_id_d;
   AddrT                  ar_addr_q, ar_addr_d;
   logic                  err_q, err_d;

   logic [IdxWidth-1:0]   r_sel;
   logic [NumReq-1:0]     r_hit, r_hs;
   logic                  r_rdy_sel, r_drop;

   logic                  ar_free, any_gnt;
   logic [NumReq-1:0]     eligible, rr_gnt;
   logic [IdxWidth-1:0]   gnt_idx;
   logic [ArbIdWidth-1:0] gnt_id;
   AddrT                  gnt_addr;

   // R return routing: beats for an unknown index or an idle requester are swallowed.
   always_comb begin
      r_sel     = mst_r_id[ArbIdWidth-1 -: IdxWidth];
      r_hit     = '0;
      r_rdy_sel = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         slv_r_id[i]   = mst_r_id[IdWidth-1:0];
         slv_r_data[i] = mst_r_data;
         if (r_sel == IdxWidth'(i)) begin
            r_hit[i]  = (cnt_q[i] != '0);
            r_rdy_sel = slv_r_ready[i];
         end
      end
      r_drop      = mst_r_valid && (r_hit == '0);
      slv_r_valid = mst_r_valid ? r_hit : '0;
      mst_r_ready = r_drop ? 1'b1 : r_rdy_sel;
      r_hs        = slv_r_valid & slv_r_ready;
   end

   // Eligibility: a full requester regains a slot in the same cycle its R beat completes.
   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         eligible[i] = slv_ar_valid[i] &&
                       ((cnt_q[i] < CntWidth'(MaxOutstanding)) || r_hs[i]);
      end
   end

   xadac_rr_arb #(
      .N    (NumReq),
      .PtrW (IdxWidth)
   ) u_rr_arb (
      .req_i (eligible),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt)
   );

   // Grant only when the output register can take a new request.
   always_comb begin
      ar_free      = !ar_valid_q || mst_ar_ready;
      slv_ar_ready = ar_free ? rr_gnt : '0;
      any_gnt      = |slv_ar_ready;
      gnt_idx      = '0;
      gnt_id       = '0;
      gnt_addr     = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (slv_ar_ready[i]) begin
            gnt_idx  = IdxWidth'(i);
            gnt_id   = {IdxWidth'(i), slv_ar_id[i]};
            gnt_addr = slv_ar_addr[i];
         end
      end
   end

   // Next-state: AR output register, rotation pointer, outstanding counters, sticky error.
   always_comb begin
      ar_valid_d = ar_valid_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      rr_ptr_d   = rr_ptr_q;
      if (any_gnt) begin
         ar_valid_d = 1'b1;
         ar_id_d    = gnt_id;
         ar_addr_d  = gnt_addr;
         rr_ptr_d   = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + IdxWidth'(1);
      end else if (ar_free) begin
         ar_valid_d = 1'b0;
         ar_id_d    = '0;
         ar_addr_d  = '0;
      end
      for (int i = 0; i < NumReq; i++) begin
         case ({slv_ar_ready[i], r_hs[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CntWidth'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CntWidth'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
      err_d = err_q | r_drop;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         ar_valid_q <= ar_valid_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign mst_ar_valid = ar_valid_q;
   assign mst_ar_id    = ar_id_q;
   assign mst_ar_addr  = ar_addr_q;
   assign err          = err_q;

endmodule

// File: tb/tb_xadac_axi_rd_arb.sv
// tb/tb_xadac_axi_rd_arb.sv - directed table-driven bench for xadac_axi_rd_arb
module tb_xadac_axi_rd_arb;
   import xadac_pkg::*;

   localparam int N  = 3;
   localparam int AW = arb_id_width(N);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   IdT      [N-1:0] slv_ar_id;
   AddrT    [N-1:0] slv_ar_addr;
   logic    [N-1:0] slv_ar_valid = '0;
   logic    [N-1:0] slv_ar_ready;
   IdT      [N-1:0] slv_r_id;
   VecDataT [N-1:0] slv_r_data;
   logic    [N-1:0] slv_r_valid;
   logic    [N-1:0] slv_r_ready = '0;
   logic [AW-1:0]   mst_ar_id;
   AddrT            mst_ar_addr;
   logic            mst_ar_valid;
   logic            mst_ar_ready = 1'b0;
   logic [AW-1:0]   mst_r_id = '0;
   VecDataT         mst_r_data = 64'hDEAD_BEEF_0123_4567;
   logic            mst_r_valid = 1'b0;
   logic            mst_r_ready;
   logic            err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xadac_axi_rd_arb #(.NumReq(N), .MaxOutstanding(4)) dut (
      .clk(clk), .rst(rst),
      .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr),
      .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
      .slv_r_id(slv_r_id), .slv_r_data(slv_r_data),
      .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
      .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr),
      .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
      .mst_r_id(mst_r_id), .mst_r_data(mst_r_data),
      .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready),
      .err(err)
   );

   typedef struct {
      logic       rst;
      logic [2:0] arv;
      logic       mrdy;
      logic       rv;
      logic [5:0] rid;
      logic [2:0] rrdy;
      logic [2:0] e_ardy;
      logic       e_mv;
      logic [5:0] e_mid;
      logic       e_mrr;
      logic [2:0] e_srv;
      logic [3:0] e_srid;
      logic       e_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, input logic [2:0] arv, input logic mrdy,
                               input logic rv, input logic [5:0] rid, input logic [2:0] rrdy,
                               input logic [2:0] ardy, input logic mv, input logic [5:0] mid,
                               input logic mrr, input logic [2:0] srv, input logic [3:0] srid,
                               input logic e);
      vec_t v;
      v.rst = r; v.arv = arv; v.mrdy = mrdy; v.rv = rv; v.rid = rid; v.rrdy = rrdy;
      v.e_ardy = ardy; v.e_mv = mv; v.e_mid = mid; v.e_mrr = mrr;
      v.e_srv = srv; v.e_srid = srid; v.e_err = e;
      return v;
   endfunction

   task automatic chk(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h", name, n, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] arv, input logic mrdy,
                        input logic rv, input logic [5:0] rid, input logic [2:0] rrdy);
      @(posedge clk);
      #1;
      rst = r; slv_ar_valid = arv; mst_ar_ready = mrdy;
      mst_r_valid = rv; mst_r_id = rid; slv_r_ready = rrdy;
      #1;
   endtask

   logic [31:0] exp_addr;

   initial begin
      slv_ar_id   = {IdT'(3), IdT'(2), IdT'(1)};
      slv_ar_addr = {AddrT'(32'h300), AddrT'(32'h200), AddrT'(32'h100)};

      // rst arv mrdy rv rid rrdy | ardy mv mid mrr srv srid err
      vq.push_back(mk(0,3'b011,1,0,6'h00,3'b000, 3'b001,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,1,0,6'h00,3'b000, 3'b010,1,6'h01,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,1,0,6'h00,3'b000, 3'b001,1,6'h12,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,1,0,6'h00,3'b000, 3'b010,1,6'h01,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,0,0,6'h00,3'b000, 3'b000,1,6'h12,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,0,0,6'h00,3'b000, 3'b000,1,6'h12,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,0,0,6'h00,3'b000, 3'b000,1,6'h12,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b011,1,0,6'h00,3'b000, 3'b001,1,6'h12,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,1,6'h01,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b001,1,0,6'h00,3'b000, 3'b001,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b001,1,0,6'h00,3'b000, 3'b000,1,6'h01,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b001,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b001,1,1,6'h01,3'b001, 3'b001,0,6'h00,1,3'b001,4'h1,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,1,6'h01,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b000, 3'b000,0,6'h00,0,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b000, 3'b000,0,6'h00,0,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b010, 3'b000,0,6'h00,1,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b010, 3'b000,0,6'h00,1,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b010, 3'b000,0,6'h00,1,3'b000,4'h5,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,1));
      vq.push_back(mk(1,3'b000,0,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,1));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b000,1,1,6'h30,3'b000, 3'b000,0,6'h00,1,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,1));
      vq.push_back(mk(0,3'b000,1,1,6'h01,3'b000, 3'b000,0,6'h00,1,3'b000,4'h1,1));
      vq.push_back(mk(1,3'b000,0,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,1));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b010,1,0,6'h00,3'b000, 3'b010,0,6'h00,0,3'b000,4'h0,0));
      vq.push_back(mk(0,3'b010,1,1,6'h15,3'b010, 3'b010,1,6'h12,1,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b010, 3'b000,1,6'h12,1,3'b010,4'h5,0));
      vq.push_back(mk(0,3'b000,1,1,6'h15,3'b010, 3'b000,0,6'h00,1,3'b000,4'h5,0));
      vq.push_back(mk(0,3'b000,1,0,6'h00,3'b000, 3'b000,0,6'h00,0,3'b000,4'h0,1));

      repeat (3) @(posedge clk);
      #2;
      chk("reset_mv", -1, 64'(mst_ar_valid), 64'h0);
      chk("reset_mid", -1, 64'(mst_ar_id), 64'h0);
      chk("reset_err", -1, 64'(err), 64'h0);

      foreach (vq[n]) begin
         drive(vq[n].rst, vq[n].arv, vq[n].mrdy, vq[n].rv, vq[n].rid, vq[n].rrdy);
         exp_addr = vq[n].e_mv ? 32'((vq[n].e_mid[5:4] + 32'd1) * 32'd256) : 32'h0;
         chk("ar_ready", n, 64'(slv_ar_ready), 64'(vq[n].e_ardy));
         chk("ar_valid", n, 64'(mst_ar_valid), 64'(vq[n].e_mv));
         chk("ar_id", n, 64'(mst_ar_id), 64'(vq[n].e_mid));
         chk("ar_addr", n, 64'(mst_ar_addr), 64'(exp_addr));
         chk("r_ready", n, 64'(mst_r_ready), 64'(vq[n].e_mrr));
         chk("r_valid", n, 64'(slv_r_valid), 64'(vq[n].e_srv));
         chk("r_id1", n, 64'(slv_r_id[1]), 64'(vq[n].e_srid));
         chk("r_data2", n, 64'(slv_r_data[2]), 64'hDEAD_BEEF_0123_4567);
         chk("err", n, 64'(err), 64'(vq[n].e_err));
      end

      // Outstanding limit: four grants, then blocked for a long stretch, then
      // an R beat to requester 0 reopens the slot in the same cycle.
      drive(1, 3'b000, 1, 0, 6'h00, 3'b000);
      for (int k = 0; k < 4; k++) begin
         drive(0, 3'b001, 1, 0, 6'h00, 3'b000);
         chk("lim_grant", 100 + k, 64'(slv_ar_ready), 64'h1);
      end
      for (int k = 0; k < 10; k++) begin
         drive(0, 3'b001, 1, 0, 6'h00, 3'b000);
         chk("lim_block", 200 + k, 64'(slv_ar_ready), 64'h0);
      end
      drive(0, 3'b001, 1, 1, 6'h01, 3'b001);
      chk("lim_reopen", 300, 64'(slv_ar_ready), 64'h1);
      chk("lim_r_ready", 300, 64'(mst_r_ready), 64'h1);
      chk("lim_r_valid", 300, 64'(slv_r_valid), 64'h1);
      drive(0, 3'b000, 1, 0, 6'h00, 3'b000);
      chk("lim_err", 301, 64'(err), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
